dlsc_uart_regbridge: RTL and testbench
======================================

Name: dlsc_uart_regbridge

Overview:
- Command decoder that consumes the UART receive FIFO interface and produces into the UART transmit FIFO interface.
- Turns a simple byte protocol into single-cycle register write and read strobes on a local register bus, then returns ACK, NAK or read data bytes.
- Sits directly downstream of the UART core's rx_pop/rx_data/rx_empty port and upstream of its tx_push/tx_data/tx_full port.
- Also monitors and clears the core's error flags.

Parameters:
- ADDR, 7, register address width (1..7); taken from cmd byte bits [ADDR-1:0].
- REGW, 32, register data width; must be a multiple of 8; BYTES = REGW/8.
- TIMEOUT, 1000000, clk cycles allowed for an inter-byte gap or a read wait before abort; must be ≥2.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  asynchronous, active-high reset.
- rx_pop  out  1  pop the receive FIFO.
- rx_data  in  8  receive FIFO head data, valid when !rx_empty.
- rx_empty  in  1  receive FIFO empty.
- tx_push  out  1  push the transmit FIFO.
- tx_data  out  8  byte to transmit.
- tx_full  in  1  transmit FIFO full.
- error_frame  in  1  sticky framing error flag from the UART core.
- error_parity  in  1  sticky parity error flag from the UART core.
- error_clear  out  1  one-cycle clear pulse to the UART core flags.
- reg_addr  out  ADDR  register address; held stable from strobe until the next command.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  REGW  write data; valid while reg_wr_en is high.
- reg_rd_en  out  1  one-cycle read request strobe.
- reg_rd_ready  in  1  read data valid; may be high in the same cycle as reg_rd_en or any later cycle.
- reg_rd_data  in  REGW  read data, sampled when reg_rd_ready is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Protocol, write: cmd byte with bit7=1 and bits[ADDR-1:0]=addr, followed by BYTES data bytes, LSB first. Response is ACK 0x06.
- Protocol, read: cmd byte with bit7=0. Response is BYTES data bytes, LSB first.
- Cmd bits [6:ADDR] are ignored.
- Reset (asynchronous): state=IDLE; every output is 0; byte counter and timeout counter are 0; shift registers are 0.
- FSM states: IDLE, WDATA, WRITE, RREQ, RWAIT, RDATA, RESP.
- rx_pop = !rx_empty && state∈{IDLE,WDATA}. It is combinational from registered state. rx_data is consumed in the same cycle as rx_pop.
- tx_push = !tx_full && state∈{RDATA,RESP}.
- IDLE:
  - On pop, latch the address.
  - bit7=1 → WDATA with byte count 0.
  - bit7=0 → RREQ.
- WDATA:
  - Each pop shifts the byte into reg_wr_data at position [8*cnt +: 8].
  - The pop that delivers byte BYTES-1 → WRITE.
- WRITE: reg_wr_en=1 for exactly 1 cycle → RESP with tx_data=0x06.
- RREQ: reg_rd_en=1 for exactly 1 cycle → RWAIT. reg_rd_ready is also sampled in this cycle.
- RWAIT: on reg_rd_ready, capture reg_rd_data → RDATA with count 0.
- RDATA:
  - tx_data = captured byte [8*cnt +: 8]. Each push increments cnt.
  - The push of the last byte → IDLE.
- RESP: hold tx_data until pushed, then → IDLE.
- Latency:
  - Write: the cmd pop plus BYTES pops, then the reg_wr_en cycle, then ACK pushed no earlier than the next cycle.
  - Read: reg_rd_en in the cycle after the cmd pop.
- Timeout counter:
  - Clears on every pop and on every state change.
  - Counts in WDATA and RWAIT.
  - On reaching TIMEOUT-1 in WDATA → IDLE silently; partial data is discarded and no strobe is issued.
  - On reaching TIMEOUT-1 in RWAIT → RESP with tx_data=0x15 (NAK); a late reg_rd_ready is ignored.
- Errors:
  - If error_frame|error_parity is sampled high, pulse error_clear=1 for one cycle, then suppress further pulses for 2 cycles so the flag can deassert.
  - If the flag is seen in WDATA → RESP with NAK 0x15 and no write.
  - If the flag is seen in IDLE, the byte popped in that cycle (if any) is discarded.
  - An error has priority over a same-cycle pop or timeout.
- Backpressure: tx_full stalls RDATA and RESP indefinitely with no timeout. The bridge never pops rx while a response is pending.
- No pipelining: one command is in flight at a time. Bytes arriving during a response remain in the rx FIFO.

Decomposition:
- Shared package dlsc_uart_regbridge_pkg holds:
  - the FSM state enum (3-bit);
  - constants ACK=8'h06, NAK=8'h15, CMD_WRITE_BIT=7.
- One natural sub-module, dlsc_uart_regbridge_timer: a loadable TIMEOUT down-counter with clear, enable and expired outputs.
- The FSM and the shift registers stay in the top module.

Test Plan:
- Write: with REGW=32, feed rx 0x85,0x78,0x56,0x34,0x12 → exactly one reg_wr_en pulse, reg_addr=0x05, reg_wr_data=0x12345678; tx emits 0x06; busy returns to 0.
- Read: feed 0x03; reg_rd_ready asserts 3 cycles after reg_rd_en with reg_rd_data=0xDEADBEEF → reg_addr=0x03; tx emits EF,BE,AD,DE in order.
- Backpressure: read as above with tx_full toggled high/low every 5 cycles → same 4 bytes, no duplicates or losses; no push while tx_full=1.
- Timeout: send 0x81 followed by 2 data bytes, then nothing for TIMEOUT cycles → no reg_wr_en; returns to IDLE; no tx. Separately, reg_rd_ready is never asserted → tx emits 0x15.
- Error: send 0x81 and 1 data byte, then raise error_parity → error_clear pulses once; tx emits 0x15; no reg_wr_en. Next valid write completes normally.
- Reset: assert rst asynchronously mid-WDATA and mid-RDATA → all outputs are 0 immediately; after release, a fresh read of 0x00 works.

Source files
------------

// File: rtl/dlsc_uart_regbridge_pkg.sv
// Shared types and protocol constants for the UART register bridge.
package dlsc_uart_regbridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WRITE = 3'd2,
        ST_RREQ  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RDATA = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    localparam logic [7:0] ACK           = 8'h06;
    localparam logic [7:0] NAK           = 8'h15;
    localparam int         CMD_WRITE_BIT = 7;

endpackage

// File: rtl/dlsc_uart_regbridge_timer.sv
// Inter-byte / read-wait watchdog: loads TIMEOUT-1 and counts down while enabled.
// Resets to zero; expired is only meaningful while en is high, and every
// entry into a counting state reloads, so the zero reset value never fires.
module dlsc_uart_regbridge_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Reload on any clear request, otherwise count down to terminal zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/dlsc_uart_regbridge.sv
// UART byte protocol to local register bus bridge.
//   state    | meaning
//   IDLE     | waiting for a command byte
//   WDATA    | collecting write data bytes, LSB first
//   WRITE    | single-cycle write strobe
//   RREQ     | single-cycle read strobe
//   RWAIT    | waiting for read data
//   RDATA    | sending read data bytes, LSB first
//   RESP     | sending a single ACK/NAK byte
module dlsc_uart_regbridge
    import dlsc_uart_regbridge_pkg::*;
#(
    parameter int ADDR    = 7,
    parameter int REGW    = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rx_pop,
    input  logic [7:0]      rx_data,
    input  logic            rx_empty,
    output logic            tx_push,
    output logic [7:0]      tx_data,
    input  logic            tx_full,
    input  logic            error_frame,
    input  logic            error_parity,
    output logic            error_clear,
    output logic [ADDR-1:0] reg_addr,
    output logic            reg_wr_en,
    output logic [REGW-1:0] reg_wr_data,
    output logic            reg_rd_en,
    input  logic            reg_rd_ready,
    input  logic [REGW-1:0] reg_rd_data,
    output logic            busy
);

    localparam int              BYTES = REGW / 8;
    localparam int              CNTW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNTW-1:0] LAST  = CNTW'(BYTES - 1);

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [ADDR-1:0] addr_n;
    logic [REGW-1:0] wr_data_n;
    logic [REGW-1:0] rd_data, rd_data_n;
    logic [7:0]      resp, resp_n;
    logic            run;
    logic [1:0]      err_block;
    logic            err_seen;
    logic            pop, push;
    logic            tmr_load, tmr_en, tmr_expired;

    // err_block keeps a still-high sticky flag from retriggering while the core clears it
    assign err_seen = (error_frame | error_parity) && (err_block == 2'd0);
    // run holds pops off until the first clock after reset so every output idles low in reset
    assign pop      = run && !rx_empty && ((state == ST_IDLE) || (state == ST_WDATA));
    assign push     = !tx_full && ((state == ST_RDATA) || (state == ST_RESP));
    assign rx_pop   = pop;
    assign tx_push  = push;
    assign reg_wr_en = (state == ST_WRITE);
    assign reg_rd_en = (state == ST_RREQ);
    assign busy      = (state != ST_IDLE);
    assign tmr_en    = (state == ST_WDATA) || (state == ST_RWAIT);
    assign tmr_load  = pop || (state_n != state);

    dlsc_uart_regbridge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Transmit byte selection from registered state.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_RDATA: tx_data = rd_data[8*cnt +: 8];
            ST_RESP:  tx_data = resp;
            default:  tx_data = 8'h00;
        endcase
    end

    // Next-state, byte counter and shift-register updates.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_n    = reg_addr;
        wr_data_n = reg_wr_data;
        rd_data_n = rd_data;
        resp_n    = resp;
        case (state)
            ST_IDLE: begin
                if (pop && !err_seen) begin
                    addr_n = rx_data[ADDR-1:0];
                    cnt_n  = '0;
                    if (rx_data[CMD_WRITE_BIT]) begin
                        wr_data_n = '0;
                        state_n   = ST_WDATA;
                    end else begin
                        state_n = ST_RREQ;
                    end
                end
            end
            ST_WDATA: begin
                if (err_seen) begin
                    resp_n  = NAK;
                    state_n = ST_RESP;
                end else if (pop) begin
                    wr_data_n[8*cnt +: 8] = rx_data;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_n = ST_WRITE;
                    end
                end else if (tmr_expired) begin
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                resp_n  = ACK;
                state_n = ST_RESP;
            end
            ST_RREQ, ST_RWAIT: begin
                if (reg_rd_ready) begin
                    rd_data_n = reg_rd_data;
                    cnt_n     = '0;
                    state_n   = ST_RDATA;
                end else if (state == ST_RREQ) begin
                    state_n = ST_RWAIT;
                end else if (tmr_expired) begin
                    resp_n  = NAK;
                    state_n = ST_RESP;
                end
            end
            ST_RDATA: begin
                if (push) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (push) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            rd_data     <= '0;
            resp        <= 8'h00;
            run         <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            reg_addr    <= addr_n;
            reg_wr_data <= wr_data_n;
            rd_data     <= rd_data_n;
            resp        <= resp_n;
            run         <= 1'b1;
        end
    end

    // Error-flag clear pulse followed by a short hold-off while the flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_clear <= 1'b0;
            err_block   <= 2'd0;
        end else begin
            error_clear <= err_seen;
            if (err_seen) begin
                err_block <= 2'd3;
            end else if (err_block != 2'd0) begin
                err_block <= err_block - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dlsc_uart_regbridge.sv
// Directed bench for the UART register bridge with a small rx FIFO model.
module tb_dlsc_uart_regbridge;

    localparam int ADDR    = 7;
    localparam int REGW    = 32;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_pop;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_empty = 1'b1;
    logic             tx_push;
    logic [7:0]       tx_data;
    logic             tx_full = 1'b0;
    logic             error_frame = 1'b0;
    logic             error_parity = 1'b0;
    logic             error_clear;
    logic [ADDR-1:0]  reg_addr;
    logic             reg_wr_en;
    logic [REGW-1:0]  reg_wr_data;
    logic             reg_rd_en;
    logic             reg_rd_ready = 1'b0;
    logic [REGW-1:0]  reg_rd_data = '0;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]      rx_q[$];
    logic [7:0]      tx_log[$];
    logic            pop_seen = 1'b0;
    int              wr_cnt = 0;
    int              rd_cnt = 0;
    int              clr_cnt = 0;
    int              push_while_full = 0;
    logic [ADDR-1:0] last_wr_addr = '0;
    logic [REGW-1:0] last_wr_data = '0;
    logic [ADDR-1:0] last_rd_addr = '0;

    dlsc_uart_regbridge #(
        .ADDR    (ADDR),
        .REGW    (REGW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .tx_push      (tx_push),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .error_frame  (error_frame),
        .error_parity (error_parity),
        .error_clear  (error_clear),
        .reg_addr     (reg_addr),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_ready (reg_rd_ready),
        .reg_rd_data  (reg_rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Observe bus activity mid-cycle, once the combinational outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_push) begin
                tx_log.push_back(tx_data);
                if (tx_full) push_while_full++;
            end
            if (reg_wr_en) begin
                wr_cnt++;
                last_wr_addr = reg_addr;
                last_wr_data = reg_wr_data;
            end
            if (reg_rd_en) begin
                rd_cnt++;
                last_rd_addr = reg_addr;
            end
            if (error_clear) clr_cnt++;
            pop_seen = rx_pop;
        end else begin
            pop_seen = 1'b0;
        end
    end

    // rx FIFO model: retire the popped head, then present the new head.
    always @(posedge clk) begin
        #1;
        if (pop_seen && (rx_q.size() > 0)) void'(rx_q.pop_front());
        pop_seen = 1'b0;
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        clr_cnt = 0;
        push_while_full = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy && (rx_q.size() == 0) && !rx_pop) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for the read strobe, then present data so it is high in cycle strobe+dly.
    task automatic serve_read(input int dly, input logic [REGW-1:0] d, output bit ok);
        int base;
        base = rd_cnt;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (dly - 1) tick();
            reg_rd_ready = 1'b1;
            reg_rd_data  = d;
            tick();
            reg_rd_ready = 1'b0;
            reg_rd_data  = '0;
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        #1;
        outs = {rx_pop, tx_push, tx_data, error_clear, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b, want 0", busy);
        end
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [31:0] d, input string tag);
        bit ok;
        clear_logs();
        rx_q.push_back(cmd);
        for (int i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
        wait_idle(100, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s_idle: bridge did not return to idle", tag); end
        n_cmp++;
        if (wr_cnt != 1) begin n_err++; $display("FAIL %s_wr_pulses: got %0d, want 1", tag, wr_cnt); end
        n_cmp++;
        if (last_wr_addr !== cmd[ADDR-1:0]) begin
            n_err++; $display("FAIL %s_addr: got %h, want %h", tag, last_wr_addr, cmd[ADDR-1:0]);
        end
        n_cmp++;
        if (last_wr_data !== d) begin
            n_err++; $display("FAIL %s_data: got %h, want %h", tag, last_wr_data, d);
        end
        n_cmp++;
        if ((tx_log.size() != 1) || (tx_log[0] !== 8'h06)) begin
            n_err++; $display("FAIL %s_ack: got %0d bytes first %h, want 1 byte 06", tag, tx_log.size(),
                              (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
        end
    endtask

    task automatic check_read_bytes(input logic [31:0] d, input string tag);
        n_cmp++;
        if (tx_log.size() != 4) begin
            n_err++; $display("FAIL %s_count: got %0d bytes, want 4", tag, tx_log.size());
        end
        for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
            n_cmp++;
            if (tx_log[i] !== d[8*i +: 8]) begin
                n_err++; $display("FAIL %s_byte%0d: got %h, want %h", tag, i, tx_log[i], d[8*i +: 8]);
            end
        end
    endtask

    task automatic test_write();
        do_write(8'h85, 32'h12345678, "write");
    endtask

    task automatic test_read();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h03);
        serve_read(3, 32'hDEADBEEF, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL read_strobe: no reg_rd_en seen"); end
        wait_idle(100, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL read_idle: bridge did not return to idle"); end
        n_cmp++;
        if ((rd_cnt != 1) || (last_rd_addr !== 7'h03)) begin
            n_err++; $display("FAIL read_req: got %0d strobes addr %h, want 1 addr 03", rd_cnt, last_rd_addr);
        end
        n_cmp++;
        if (reg_addr !== 7'h03) begin n_err++; $display("FAIL read_addr_hold: got %h, want 03", reg_addr); end
        check_read_bytes(32'hDEADBEEF, "read");
    endtask

    task automatic test_backpressure();
        bit ok_s, ok_i;
        clear_logs();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat (5) tick();
                    tx_full = ~tx_full;
                end
                tx_full = 1'b0;
            end
            begin
                rx_q.push_back(8'h03);
                serve_read(3, 32'hDEADBEEF, ok_s);
                wait_idle(200, ok_i);
            end
        join
        n_cmp++;
        if (!ok_s || !ok_i) begin n_err++; $display("FAIL bp_done: strobe %b idle %b, want 1 1", ok_s, ok_i); end
        n_cmp++;
        if (push_while_full != 0) begin
            n_err++; $display("FAIL bp_push_full: got %0d pushes while full, want 0", push_while_full);
        end
        check_read_bytes(32'hDEADBEEF, "bp");
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h81);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        repeat (6) tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL to_wr_pending: busy %b, want 1", busy); end
        repeat (TIMEOUT + 10) tick();
        n_cmp++;
        if ((wr_cnt != 0) || (busy !== 1'b0) || (tx_log.size() != 0)) begin
            n_err++; $display("FAIL to_wr_abort: wr %0d busy %b tx %0d, want 0 0 0", wr_cnt, busy, tx_log.size());
        end
        clear_logs();
        rx_q.push_back(8'h01);
        wait_idle(TIMEOUT + 50, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL to_rd_idle: bridge did not return to idle"); end
        n_cmp++;
        if ((rd_cnt != 1) || (tx_log.size() != 1) || (tx_log[0] !== 8'h15)) begin
            n_err++; $display("FAIL to_rd_nak: rd %0d tx %0d first %h, want 1 1 15", rd_cnt, tx_log.size(),
                              (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
        end
    endtask

    task automatic test_error();
        int b;
        clear_logs();
        rx_q.push_back(8'h81);
        rx_q.push_back(8'hAA);
        repeat (5) tick();
        error_parity = 1'b1;
        b = 0;
        while ((clr_cnt == 0) && (b < 20)) begin
            tick();
            b++;
        end
        error_parity = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (clr_cnt != 1) begin n_err++; $display("FAIL err_clear: got %0d pulses, want 1", clr_cnt); end
        n_cmp++;
        if ((tx_log.size() != 1) || (tx_log[0] !== 8'h15)) begin
            n_err++; $display("FAIL err_nak: got %0d bytes first %h, want 1 byte 15", tx_log.size(),
                              (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
        end
        n_cmp++;
        if ((wr_cnt != 0) || (busy !== 1'b0)) begin
            n_err++; $display("FAIL err_nowrite: wr %0d busy %b, want 0 0", wr_cnt, busy);
        end
        do_write(8'h90, 32'h04030201, "err_recover");
    endtask

    task automatic test_back_to_back_reset();
        logic [63:0] outs;
        bit ok;
        clear_logs();
        rx_q.push_back(8'h81);
        rx_q.push_back(8'h01);
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rst_wdata_busy: got %b, want 1", busy); end
        rx_q.delete();
        #1 rst = 1'b1;
        #1;
        outs = {rx_pop, tx_push, tx_data, error_clear, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy};
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL rst_wdata_outputs: got %h, want 0", outs); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_logs();
        tx_full = 1'b1;
        rx_q.push_back(8'h00);
        serve_read(1, 32'h11223344, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok || (busy !== 1'b1) || (tx_data !== 8'h44) || (tx_push !== 1'b0)) begin
            n_err++; $display("FAIL rst_rdata_stall: strobe %b busy %b data %h push %b, want 1 1 44 0",
                              ok, busy, tx_data, tx_push);
        end
        #1 rst = 1'b1;
        #1;
        outs = {rx_pop, tx_push, tx_data, error_clear, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy};
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL rst_rdata_outputs: got %h, want 0", outs); end
        tx_full = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_logs();
        rx_q.push_back(8'h00);
        serve_read(2, 32'hCAFEF00D, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rst_fresh_strobe: no reg_rd_en seen"); end
        wait_idle(100, ok);
        n_cmp++;
        if (!ok || (reg_addr !== 7'h00)) begin
            n_err++; $display("FAIL rst_fresh_idle: idle %b addr %h, want 1 00", ok, reg_addr);
        end
        check_read_bytes(32'hCAFEF00D, "rst_fresh");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_error();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
